// File: rtl/md_unit.sv
// E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO.
// busy is registered and falls on the same edge that HI/LO take the result.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             issue, finish;
  md_op_t           op_in;
  md_op_t           op_p0;
  logic [31:0]      a_p0, b_p0;
  logic [63:0]      res;
  logic             res_ok;

  assign op_in = md_op_t'(md_op);

  // Operands are zero- or sign-extended to 64 bits so one multiplier serves both flavours.
  function automatic logic [63:0] mul64(input logic is_signed, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = is_signed ? {{32{a[31]}}, a} : {32'h0, a};
    sb = is_signed ? {{32{b[31]}}, b} : {32'h0, b};
    return sa * sb;
  endfunction

  // 64-bit division keeps 0x80000000 / -1 representable; result packed as {rem, quo}.
  function automatic logic [63:0] div64(input logic is_signed, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = is_signed ? {{32{a[31]}}, a} : {32'h0, a};
    sb = is_signed ? {{32{b[31]}}, b} : {32'h0, b};
    if (b == 32'h0) return 64'h0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always_comb begin
    res    = 64'h0;
    res_ok = 1'b0;
    case (op_p0)
      OP_MULT:  begin res = mul64(1'b1, a_p0, b_p0); res_ok = 1'b1;     end
      OP_MULTU: begin res = mul64(1'b0, a_p0, b_p0); res_ok = 1'b1;     end
      OP_DIV:   begin res = div64(1'b1, a_p0, b_p0); res_ok = |b_p0;    end
      OP_DIVU:  begin res = div64(1'b0, a_p0, b_p0); res_ok = |b_p0;    end
      default:  ;
    endcase
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (op_in inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
          issue      = 1'b1;
          next_state = RUN;
          cnt_next   = (op_in inside {OP_MULT, OP_MULTU}) ? MULT_N : DIV_N;
        end
      end
      RUN: begin
        cnt_next = cnt - ONE;
        if (cnt == ONE) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      busy  <= (next_state == RUN);
    end
  end

  // Stage p0: operand latch at issue; HI/LO writeback at completion or MT op in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_p0 <= OP_NONE;
      a_p0  <= '0;
      b_p0  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (issue) begin
        op_p0 <= op_in;
        a_p0  <= rs_e;
        b_p0  <= rt_e;
      end
      if (finish) begin
        if (res_ok) begin
          hi <= res[63:32];
          lo <= res[31:0];
        end
      end else if (state == IDLE && op_in == OP_MTHI) begin
        hi <= rs_e;
      end else if (state == IDLE && op_in == OP_MTLO) begin
        lo <= rs_e;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed literal cases plus randomized traffic
// compared every cycle against a timeline-based model of HI/LO and busy.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_e = 32'h0;
  logic [31:0] rt_e = 32'h0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_e(rs_e), .rt_e(rt_e),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] h,
                                   output logic [31:0] l, output bit ok);
    longint sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ok = 1'b1;
    h = 32'h0;
    l = 32'h0;
    case (op)
      3'd1: begin q = sa * sb; h = q[63:32]; l = q[31:0]; end
      3'd2: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
      3'd3: begin
        if (b == 32'h0) ok = 1'b0;
        else begin q = sa / sb; r = sa - q * sb; h = r[31:0]; l = q[31:0]; end
      end
      3'd4: begin
        if (b == 32'h0) ok = 1'b0;
        else begin l = a / b; h = a % b; end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // Model: an issued op owns the unit until an absolute edge number, then commits.
  int          edge_n = 0;
  int          done_edge = 0;
  bit          pend = 1'b0;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0, p_hi = 32'h0, p_lo = 32'h0;
  bit          p_ok = 1'b0;

  always @(posedge clk) begin
    logic [31:0] th, tl;
    bit tok;
    edge_n <= edge_n + 1;
    if (reset) begin
      pend <= 1'b0;
      m_hi <= 32'h0;
      m_lo <= 32'h0;
    end else if (pend) begin
      if (edge_n == done_edge) begin
        pend <= 1'b0;
        if (p_ok) begin
          m_hi <= p_hi;
          m_lo <= p_lo;
        end
      end
    end else if (md_op >= 3'd1 && md_op <= 3'd4) begin
      ref_calc(md_op, rs_e, rt_e, th, tl, tok);
      pend      <= 1'b1;
      done_edge <= edge_n + ((md_op <= 3'd2) ? MC : DC);
      p_hi      <= th;
      p_lo      <= tl;
      p_ok      <= tok;
    end else if (md_op == 3'd5) begin
      m_hi <= rs_e;
    end else if (md_op == 3'd6) begin
      m_lo <= rs_e;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'h0, busy}, {31'h0, pend});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op = op;
    rs_e  = a;
    rt_e  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run(3'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    run(3'd0, 32'h0, 32'h0);
    run(3'd0, 32'h0, 32'h0);
    chk_en = 1'b1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b0;

    // MULT -3 * 5
    run(3'd1, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_first", {31'h0, busy}, 32'h1);
    idle(MC - 1);
    chk("mult_busy_last", {31'h0, busy}, 32'h1);
    idle(1);
    chk("mult_busy_fall", {31'h0, busy}, 32'h0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // MULTU, issued on the first idle cycle
    run(3'd2, 32'hFFFF_FFFF, 32'd2);
    idle(MC);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIVU 7/2 and DIV -7/2
    run(3'd4, 32'd7, 32'd2);
    idle(DC);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run(3'd3, 32'hFFFF_FFF9, 32'd2);
    idle(DC);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // MTLO ignored while busy, honoured in IDLE
    run(3'd1, 32'd2, 32'd3);
    run(3'd6, 32'h1234, 32'h0);
    idle(MC - 1);
    chk("mtlo_busy_lo", lo, 32'd6);
    run(3'd6, 32'h1234, 32'h0);
    chk("mtlo_idle_lo", lo, 32'h1234);
    chk("mtlo_idle_busy", {31'h0, busy}, 32'h0);

    // Divide by zero leaves HI/LO; overflow case
    run(3'd5, 32'hA, 32'h0);
    run(3'd6, 32'hB, 32'h0);
    run(3'd3, 32'd5, 32'd0);
    idle(DC - 1);
    chk("div0_busy", {31'h0, busy}, 32'h1);
    idle(1);
    chk("div0_hi", hi, 32'hA);
    chk("div0_lo", lo, 32'hB);
    run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DC);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // Reset on third busy cycle of a MULT
    run(3'd1, 32'd7, 32'd7);
    idle(2);
    reset = 1'b1;
    run(3'd0, 32'h0, 32'h0);
    reset = 1'b0;
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    idle(MC + 2);
    chk("rstmid_late_hi", hi, 32'h0);
    chk("rstmid_late_lo", lo, 32'h0);

    // Randomized traffic, including ops presented while busy and occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 249) == 0);
      md_op = 3'($urandom_range(0, 7));
      rs_e  = pick();
      rt_e  = pick();
    end
    @(negedge clk);
    reset = 1'b0;
    md_op = 3'd0;
    begin
      int n = 0;
      while (busy && n < 2 * DC) begin
        @(negedge clk);
        n++;
      end
      chk("drain_busy", {31'h0, busy}, 32'h0);
    end
    idle(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
